// File: rtl/vram_blit.sv
// VRAM block-transfer engine: fills a run of words with a constant or copies
// a run from one VRAM region to another through an arbitrated VRAM port.
`timescale 1ns/1ps

package xosera_pkg;
    typedef logic [15:0] addr_t;
    typedef logic [15:0] word_t;
endpackage

module vram_blit
    import xosera_pkg::*;
(
    input  logic        clk,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic        copy_i,
    input  addr_t       src_addr_i,
    input  addr_t       dst_addr_i,
    input  word_t       count_i,
    input  word_t       fill_data_i,
    input  logic [3:0]  mask_i,
    input  logic        vram_grant_i,
    output logic        vram_sel_o,
    output logic        vram_wr_o,
    output logic [3:0]  vram_mask_o,
    output addr_t       vram_addr_o,
    output word_t       vram_data_o,
    input  word_t       vram_data_i,
    output logic        busy_o,
    output logic        done_o
);

    typedef enum logic [1:0] {IDLE, FILL, RD, WR} state_t;

    state_t      r_state;
    addr_t       r_src;
    addr_t       r_dst;
    word_t       r_count;
    word_t       r_fill;
    logic [3:0]  r_mask;
    word_t       r_hold;
    logic        r_first;
    logic        r_done;

    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_state <= IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_count <= '0;
            r_fill  <= '0;
            r_mask  <= '0;
            r_hold  <= '0;
            r_first <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // Read data is only valid one cycle after the granted read, so grab
            // it unconditionally in case the following write gets stalled.
            if (r_first) begin
                r_hold  <= vram_data_i;
                r_first <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_src   <= src_addr_i;
                        r_dst   <= dst_addr_i;
                        r_count <= count_i;
                        r_fill  <= fill_data_i;
                        r_mask  <= mask_i;
                        if (count_i == 16'd0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= copy_i ? RD : FILL;
                        end
                    end
                end
                FILL: begin
                    if (vram_grant_i) begin
                        r_dst   <= r_dst + 16'd1;
                        r_count <= r_count - 16'd1;
                        if (r_count == 16'd1) begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                RD: begin
                    if (vram_grant_i) begin
                        r_src   <= r_src + 16'd1;
                        r_first <= 1'b1;
                        r_state <= WR;
                    end
                end
                WR: begin
                    if (vram_grant_i) begin
                        r_dst   <= r_dst + 16'd1;
                        r_count <= r_count - 16'd1;
                        if (r_count > 16'd1) begin
                            r_state <= RD;
                        end else begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        vram_sel_o  = 1'b0;
        vram_wr_o   = 1'b0;
        vram_mask_o = 4'h0;
        vram_addr_o = '0;
        vram_data_o = '0;
        case (r_state)
            FILL: begin
                vram_sel_o  = 1'b1;
                vram_wr_o   = 1'b1;
                vram_mask_o = r_mask;
                vram_addr_o = r_dst;
                vram_data_o = r_fill;
            end
            RD: begin
                vram_sel_o  = 1'b1;
                vram_addr_o = r_src;
            end
            WR: begin
                vram_sel_o  = 1'b1;
                vram_wr_o   = 1'b1;
                vram_mask_o = r_mask;
                vram_addr_o = r_dst;
                vram_data_o = r_first ? vram_data_i : r_hold;
            end
            default: ;
        endcase
    end

    assign busy_o = (r_state != IDLE);
    assign done_o = r_done;

endmodule

// File: tb/tb_vram_blit.sv
// Directed bench for vram_blit: a nibble-masked VRAM model with arbitrary
// grant, plus hand-computed checks of fill, copy, wrap, mask and abort.
`timescale 1ns/1ps

module tb_vram_blit;

    logic        clk = 1'b0;
    logic        rst, start, copy, grant;
    logic [15:0] src, dst, count, fill;
    logic [3:0]  mask;
    logic        sel, wr, busy, done;
    logic [3:0]  vmask;
    logic [15:0] vaddr, wdata;
    logic [15:0] rdata = 16'hDEAD;

    always #5 clk = ~clk;

    vram_blit dut (
        .clk          (clk),
        .reset_i      (rst),
        .start_i      (start),
        .copy_i       (copy),
        .src_addr_i   (src),
        .dst_addr_i   (dst),
        .count_i      (count),
        .fill_data_i  (fill),
        .mask_i       (mask),
        .vram_grant_i (grant),
        .vram_sel_o   (sel),
        .vram_wr_o    (wr),
        .vram_mask_o  (vmask),
        .vram_addr_o  (vaddr),
        .vram_data_o  (wdata),
        .vram_data_i  (rdata),
        .busy_o       (busy),
        .done_o       (done)
    );

    logic [15:0] mem [0:65535];
    logic [15:0] log_addr [0:255];
    logic        pl_en = 1'b0;
    logic [15:0] pl_addr = 16'h0, pl_data = 16'h0;
    int          wr_cnt = 0;
    int          sel_cnt = 0;
    logic [15:0] bm;

    assign bm = {{4{vmask[3]}}, {4{vmask[2]}}, {4{vmask[1]}}, {4{vmask[0]}}};

    // VRAM model: read data appears the cycle after a granted read, garbage otherwise.
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        if (sel && grant) begin
            if (wr) begin
                mem[vaddr] <= (mem[vaddr] & ~bm) | (wdata & bm);
                log_addr[wr_cnt[7:0]] <= vaddr;
                wr_cnt <= wr_cnt + 1;
                rdata <= 16'hDEAD;
            end else begin
                rdata <= mem[vaddr];
            end
        end else begin
            rdata <= 16'hDEAD;
        end
        if (sel) sel_cnt <= sel_cnt + 1;
    end

    int passed = 0;
    int total = 0;
    int n, base, sc;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy && cycles < 200) begin
            cycles++;
            tick();
        end
    endtask

    task automatic go(input logic c, input logic [15:0] s, input logic [15:0] d,
                      input logic [15:0] cnt, input logic [15:0] f, input logic [3:0] m);
        start = 1'b1; copy = c; src = s; dst = d; count = cnt; fill = f; mask = m;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; copy = 1'b0; grant = 1'b1;
        src = 16'h0; dst = 16'h0; count = 16'h0; fill = 16'h0; mask = 4'h0;
        tick(); tick();
        check("reset_busy", 16'(busy), 16'h0);
        check("reset_done", 16'(done), 16'h0);
        check("reset_sel",  16'(sel),  16'h0);
        check("reset_addr", vaddr, 16'h0);
        check("reset_data", wdata, 16'h0);
        rst = 1'b0;
        tick();

        // Fill 4 words at full grant
        base = wr_cnt;
        go(1'b0, 16'h0, 16'h0100, 16'd4, 16'hABCD, 4'hF);
        check("fill_busy",  16'(busy), 16'h1);
        check("fill_sel",   16'(sel),  16'h1);
        check("fill_wr",    16'(wr),   16'h1);
        check("fill_addr0", vaddr, 16'h0100);
        check("fill_data",  wdata, 16'hABCD);
        check("fill_mask",  16'(vmask), 16'hF);
        wait_idle(n);
        check("fill_busy_cycles", 16'(n), 16'd4);
        check("fill_done", 16'(done), 16'h1);
        check("fill_nwrites", 16'(wr_cnt - base), 16'd4);
        for (int i = 0; i < 4; i++)
            check("fill_log_addr", log_addr[8'(base + i)], 16'h0100 + 16'(i));
        tick();
        check("fill_done_pulse", 16'(done), 16'h0);
        check("fill_mem", mem[16'h0103], 16'hABCD);

        // Copy 3 words with a 2-cycle stall in the first write
        preload(16'h0010, 16'h0001);
        preload(16'h0011, 16'h0002);
        preload(16'h0012, 16'h0003);
        go(1'b1, 16'h0010, 16'h0200, 16'd3, 16'h0, 4'hF);
        base = wr_cnt;
        n = 0;
        while (busy && n < 40) begin
            n++;
            grant = (n == 2 || n == 3) ? 1'b0 : 1'b1;
            if (n == 1) begin
                check("copy_rd_addr", vaddr, 16'h0010);
                check("copy_rd_wr", 16'(wr), 16'h0);
            end
            if (n == 2) begin
                check("copy_wr_first_data", wdata, 16'h0001);
                check("copy_wr_addr", vaddr, 16'h0200);
            end
            if (n == 3) begin
                check("copy_hold_data", wdata, 16'h0001);
                check("copy_stall_addr", vaddr, 16'h0200);
                check("copy_stall_nowrite", 16'(wr_cnt - base), 16'd0);
            end
            tick();
        end
        grant = 1'b1;
        check("copy_busy_cycles", 16'(n), 16'd8);
        check("copy_done", 16'(done), 16'h1);
        check("copy_mem0", mem[16'h0200], 16'h0001);
        check("copy_mem1", mem[16'h0201], 16'h0002);
        check("copy_mem2", mem[16'h0202], 16'h0003);
        tick();

        // Address wrap
        base = wr_cnt;
        go(1'b0, 16'h0, 16'hFFFE, 16'd3, 16'h1234, 4'hF);
        wait_idle(n);
        check("wrap_a0", log_addr[8'(base)],     16'hFFFE);
        check("wrap_a1", log_addr[8'(base + 1)], 16'hFFFF);
        check("wrap_a2", log_addr[8'(base + 2)], 16'h0000);
        check("wrap_mem", mem[16'h0000], 16'h1234);
        tick();

        // Zero count
        sc = sel_cnt;
        go(1'b0, 16'h0, 16'h0600, 16'd0, 16'h5555, 4'hF);
        check("zero_done", 16'(done), 16'h1);
        check("zero_busy", 16'(busy), 16'h0);
        tick();
        check("zero_done_pulse", 16'(done), 16'h0);
        check("zero_no_sel", 16'(sel_cnt - sc), 16'd0);

        // Nibble mask
        preload(16'h0300, 16'h0000);
        go(1'b0, 16'h0, 16'h0300, 16'd1, 16'hFFFF, 4'h5);
        wait_idle(n);
        check("mask_mem", mem[16'h0300], 16'h0F0F);
        tick();

        // Abort mid-copy; reset wins over a simultaneous start
        preload(16'h0401, 16'h0000);
        go(1'b1, 16'h0010, 16'h0400, 16'd3, 16'h0, 4'hF);
        tick(); tick();
        rst = 1'b1;
        start = 1'b1; copy = 1'b0; dst = 16'h0700; count = 16'd5;
        tick();
        check("abort_busy", 16'(busy), 16'h0);
        check("abort_done", 16'(done), 16'h0);
        check("abort_sel",  16'(sel),  16'h0);
        check("abort_wr",   16'(wr),   16'h0);
        check("abort_addr", vaddr, 16'h0);
        check("abort_data", wdata, 16'h0);
        check("abort_mask", 16'(vmask), 16'h0);
        rst = 1'b0; start = 1'b0;
        tick();
        check("abort_no_done", 16'(done), 16'h0);
        check("abort_no_start", 16'(busy), 16'h0);
        check("abort_written", mem[16'h0400], 16'h0001);
        check("abort_unwritten", mem[16'h0401], 16'h0000);

        // Restart after abort
        go(1'b0, 16'h0, 16'h0500, 16'd2, 16'h7777, 4'hF);
        check("restart_busy", 16'(busy), 16'h1);
        wait_idle(n);
        check("restart_cycles", 16'(n), 16'd2);
        check("restart_done", 16'(done), 16'h1);
        check("restart_mem", mem[16'h0501], 16'h7777);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
